// File: rtl/pc_sequencer_vliw.sv
// VLIW fetch-stage program counter with a circular return-address stack.
// State advances on the falling clock edge; reset is asynchronous and active-high.
module pc_sequencer_vliw #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned ISSUE_BYTES = 8,
   parameter int unsigned RAS_DEPTH   = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         branchTaken,
   input  logic                         call,
   input  logic                         ret,
   input  logic [WIDTH-1:0]             branchTarget,
   output logic [WIDTH-1:0]             pcOut,
   output logic [WIDTH-1:0]             pcPlus,
   output logic [$clog2(RAS_DEPTH):0]   rasCount,
   output logic                         rasEmpty,
   output logic                         rasFull,
   output logic                         rasOverflow,
   output logic                         rasUnderflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(ISSUE_BYTES - 1));

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push;
   logic [PW-1:0]    top_idx;
   logic [WIDTH-1:0] target_aligned;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];

   assign pcPlus         = pc_q + WIDTH'(ISSUE_BYTES);
   assign target_aligned = branchTarget & ALIGN_MASK;
   assign top_idx        = ptr_q - 1'b1;

   // Priority: stall > ret > call > branchTaken > sequential.
   always_comb begin
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (count_q != '0) begin
               pc_d    = ras_q[top_idx];
               ptr_d   = top_idx;
               count_d = count_q - 1'b1;
            end else begin
               pc_d  = pcPlus;
               unf_d = 1'b1;
            end
         end else if (call) begin
            pc_d  = target_aligned;
            push  = 1'b1;
            ptr_d = ptr_q + 1'b1;
            // When full the write lands on the oldest entry; depth stays saturated.
            if (count_q == CW'(RAS_DEPTH)) begin
               ovf_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else if (branchTaken) begin
            pc_d = target_aligned;
         end else begin
            pc_d = pcPlus;
         end
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack contents are don't-care after reset, so no reset on the storage.
   always_ff @(negedge clk) begin
      if (push) begin
         ras_q[ptr_q] <= pcPlus;
      end
   end

   assign pcOut        = pc_q;
   assign rasCount     = count_q;
   assign rasEmpty     = (count_q == '0);
   assign rasFull      = (count_q == CW'(RAS_DEPTH));
   assign rasOverflow  = ovf_q;
   assign rasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer_vliw.sv
// Directed testbench for pc_sequencer_vliw (default parameters).
module tb_pc_sequencer_vliw;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branchTaken = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [31:0] branchTarget = '0;
   logic [31:0] pcOut;
   logic [31:0] pcPlus;
   logic [2:0]  rasCount;
   logic        rasEmpty;
   logic        rasFull;
   logic        rasOverflow;
   logic        rasUnderflow;

   int tests_run = 0;
   int tests_failed = 0;

   pc_sequencer_vliw dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branchTaken  (branchTaken),
      .call         (call),
      .ret          (ret),
      .branchTarget (branchTarget),
      .pcOut        (pcOut),
      .pcPlus       (pcPlus),
      .rasCount     (rasCount),
      .rasEmpty     (rasEmpty),
      .rasFull      (rasFull),
      .rasOverflow  (rasOverflow),
      .rasUnderflow (rasUnderflow)
   );

   always #5 clk = ~clk;

   // Apply controls for one falling edge, then return 1 time unit after it with controls idle.
   task automatic step(input logic s, input logic b, input logic c, input logic r,
                       input logic [31:0] t);
      stall = s; branchTaken = b; call = c; ret = r; branchTarget = t;
      @(negedge clk);
      #1;
      stall = 1'b0; branchTaken = 1'b0; call = 1'b0; ret = 1'b0; branchTarget = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'h08; exp_seq[1] = 32'h10; exp_seq[2] = 32'h18;
      #3;
      tests_run++;
      if (pcOut !== 32'h0 || rasCount !== 3'd0 || rasOverflow !== 1'b0 || rasUnderflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state pc=%h cnt=%0d ovf=%b unf=%b exp pc=0 cnt=0 ovf=0 unf=0",
                  pcOut, rasCount, rasOverflow, rasUnderflow);
      end
      tests_run++;
      if (pcPlus !== 32'h8) begin
         tests_failed++;
         $display("FAIL reset_pcplus got=%h exp=%h", pcPlus, 32'h8);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, '0);
         tests_run++;
         if (pcOut !== exp_seq[i] || rasEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq%0d pc=%h empty=%b exp pc=%h empty=1", i, pcOut, rasEmpty, exp_seq[i]);
         end
      end
   endtask

   task automatic test_branch();
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h103);
      tests_run++;
      if (pcOut !== 32'h100) begin
         tests_failed++;
         $display("FAIL branch_align got=%h exp=%h", pcOut, 32'h100);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (pcOut !== 32'h108 || rasCount !== 3'd0) begin
         tests_failed++;
         $display("FAIL branch_seq pc=%h cnt=%0d exp pc=108 cnt=0", pcOut, rasCount);
      end
   endtask

   task automatic test_call_ret();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h400);
      tests_run++;
      if (pcOut !== 32'h400 || rasCount !== 3'd1) begin
         tests_failed++;
         $display("FAIL call pc=%h cnt=%0d exp pc=400 cnt=1", pcOut, rasCount);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (pcOut !== 32'h410) begin
         tests_failed++;
         $display("FAIL call_seq got=%h exp=%h", pcOut, 32'h410);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      tests_run++;
      if (pcOut !== 32'h110 || rasEmpty !== 1'b1 || rasOverflow !== 1'b0 || rasUnderflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ret pc=%h empty=%b ovf=%b unf=%b exp pc=110 empty=1 ovf=0 unf=0",
                  pcOut, rasEmpty, rasOverflow, rasUnderflow);
      end
   endtask

   task automatic test_overflow_underflow();
      logic [31:0] exp_ret [5];
      exp_ret[0] = 32'h4008; exp_ret[1] = 32'h3008; exp_ret[2] = 32'h2008;
      exp_ret[3] = 32'h1008; exp_ret[4] = 32'h1010;
      pulse_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'(i) << 12);
         if (i == 4) begin
            tests_run++;
            if (rasFull !== 1'b1 || rasOverflow !== 1'b0) begin
               tests_failed++;
               $display("FAIL fill full=%b ovf=%b exp full=1 ovf=0", rasFull, rasOverflow);
            end
         end
      end
      tests_run++;
      if (pcOut !== 32'h5000 || rasCount !== 3'd4 || rasOverflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL overflow pc=%h cnt=%0d ovf=%b exp pc=5000 cnt=4 ovf=1",
                  pcOut, rasCount, rasOverflow);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, '0);
         tests_run++;
         if (pcOut !== exp_ret[i] || rasUnderflow !== (i == 4)) begin
            tests_failed++;
            $display("FAIL ret%0d pc=%h unf=%b exp pc=%h unf=%b", i, pcOut, rasUnderflow,
                     exp_ret[i], (i == 4));
         end
      end
      tests_run++;
      if (rasCount !== 3'd0 || rasOverflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL after_pops cnt=%0d ovf=%b exp cnt=0 ovf=1", rasCount, rasOverflow);
      end
   endtask

   task automatic test_wrap_stall();
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
      tests_run++;
      if (pcOut !== 32'hFFFF_FFF8 || pcPlus !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap_setup pc=%h plus=%h exp pc=fffffff8 plus=0", pcOut, pcPlus);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (pcOut !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap got=%h exp=%h", pcOut, 32'h0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (pcOut !== 32'h0) begin
         tests_failed++;
         $display("FAIL stall got=%h exp=%h", pcOut, 32'h0);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h777);
      tests_run++;
      if (pcOut !== 32'h0 || rasCount !== 3'd0 || rasOverflow !== 1'b1 || rasUnderflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_ctl pc=%h cnt=%0d ovf=%b unf=%b exp pc=0 cnt=0 ovf=1 unf=1",
                  pcOut, rasCount, rasOverflow, rasUnderflow);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (pcOut !== 32'h8) begin
         tests_failed++;
         $display("FAIL unstall got=%h exp=%h", pcOut, 32'h8);
      end
   endtask

   task automatic test_ret_call_same();
      // pc=8: call 0x200 pushes 0x10; then ret+call together pops 0x10 and pushes nothing.
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h600);
      tests_run++;
      if (pcOut !== 32'h10 || rasCount !== 3'd0) begin
         tests_failed++;
         $display("FAIL ret_call pc=%h cnt=%0d exp pc=10 cnt=0", pcOut, rasCount);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h30C);
      tests_run++;
      if (pcOut !== 32'h308 || rasCount !== 3'd1) begin
         tests_failed++;
         $display("FAIL call_branch pc=%h cnt=%0d exp pc=308 cnt=1", pcOut, rasCount);
      end
   endtask

   task automatic test_async_reset();
      pulse_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h400);
      tests_run++;
      if (pcOut !== 32'h400 || rasCount !== 3'd2) begin
         tests_failed++;
         $display("FAIL pre_reset pc=%h cnt=%0d exp pc=400 cnt=2", pcOut, rasCount);
      end
      #1;
      reset = 1'b1;
      #1;
      tests_run++;
      if (pcOut !== 32'h0 || rasCount !== 3'd0 || rasOverflow !== 1'b0 || rasUnderflow !== 1'b0 ||
          pcPlus !== 32'h8) begin
         tests_failed++;
         $display("FAIL async_reset pc=%h plus=%h cnt=%0d ovf=%b unf=%b exp pc=0 plus=8 cnt=0",
                  pcOut, pcPlus, rasCount, rasOverflow, rasUnderflow);
      end
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (pcOut !== 32'h8) begin
         tests_failed++;
         $display("FAIL post_reset got=%h exp=%h", pcOut, 32'h8);
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_call_ret();
      test_overflow_underflow();
      test_wrap_stall();
      test_ret_call_same();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_sequencer_vliw.md
Name: pc_sequencer_vliw

Overview:
- Parametrised program-counter unit for the VLIW fetch stage.
- Holds the current bundle address and advances it by one issue-bundle stride each cycle.
- Supports redirects from branch resolution, call and return.
- Provides a small return-address stack (RAS), stall freeze, and sticky RAS error flags for the control/debug path.

Parameters:
WIDTH, 32, PC / address width in bits
ISSUE_BYTES, 8, bundle stride in bytes; power of two, >= 4
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset; low log2(ISSUE_BYTES) bits must be 0

Ports:
clk  in  1  clock; all state updates on the falling edge, as for the existing PC register
reset  in  1  asynchronous, active-high; clears all state immediately
stall  in  1  freeze PC and RAS this cycle
branchTaken  in  1  redirect to branchTarget
call  in  1  redirect to branchTarget and push return address
ret  in  1  redirect to popped RAS top
branchTarget  in  WIDTH  redirect address for branch/call
pcOut  out  WIDTH  current bundle PC (registered)
pcPlus  out  WIDTH  pcOut + ISSUE_BYTES (combinational)
rasCount  out  log2(RAS_DEPTH)+1  valid RAS entries
rasEmpty  out  1  rasCount == 0
rasFull  out  1  rasCount == RAS_DEPTH
rasOverflow  out  1  sticky; a push occurred while full
rasUnderflow  out  1  sticky; a pop occurred while empty

Behaviour:
- Reset (asynchronous, active-high, takes effect without a clock edge): pcOut=RESET_PC, rasCount=0, RAS pointer=0, rasOverflow=0, rasUnderflow=0. RAS contents are don't-care.
- Controls are sampled at the falling edge of clk. pcOut updates at that same edge, giving one-edge latency from redirect to new PC.
- Per-edge priority (highest first): stall > ret > call > branchTaken > sequential.
  - stall=1: pcOut, RAS and flags all hold; other controls are ignored.
  - ret: if rasCount>0, pcOut <= RAS top, then pop (pointer-1, count-1). If rasCount==0, pcOut <= pcPlus, rasUnderflow <= 1, count stays 0.
  - call: pcOut <= aligned branchTarget; push pcPlus.
    - If not full, count+1.
    - If full, the oldest entry is overwritten (circular pointer), count stays RAS_DEPTH, rasOverflow <= 1.
  - branchTaken (with call=0, ret=0): pcOut <= aligned branchTarget; RAS unchanged.
  - Otherwise: pcOut <= pcPlus.
- call and branchTaken asserted together behaves as call.
- ret and call asserted together: ret wins and no push occurs.
- Alignment: the low log2(ISSUE_BYTES) bits of branchTarget are forced to 0 before loading into pcOut or the RAS.
- Arithmetic is modulo 2^WIDTH; pcPlus wraps silently, with no flag.
- The RAS is a circular buffer of RAS_DEPTH x WIDTH. The top is the entry at (pointer-1) mod RAS_DEPTH. The pointer wraps modulo RAS_DEPTH.
- Sticky flags clear only on reset.
- Reset asserted mid-operation forces the reset state at once. After deassertion, the first falling edge performs a normal sequential step from RESET_PC.
- pcPlus tracks pcOut combinationally, including during reset (RESET_PC + ISSUE_BYTES).

Test Plan:
- Reset pulse, then 3 falling edges with no controls -> pcOut = 0x00, 0x08, 0x10, 0x18; rasEmpty=1.
- At pcOut=0x18, branchTaken=1, branchTarget=0x103 for one edge -> pcOut=0x100; next edge 0x108; rasCount=0.
- At pcOut=0x108, call to 0x400 -> pcOut=0x400, rasCount=1. Two sequential edges give 0x410. ret -> pcOut=0x110, rasEmpty=1, no flags.
- RAS_DEPTH=4: five calls from PCs 0x0, 0x1000, 0x2000, 0x3000, 0x4000 (each targeting the next) -> rasOverflow=1, rasCount=4. Five rets -> 0x4008, 0x3008, 0x2008, 0x1008, then the fifth ret gives pcPlus with rasUnderflow=1.
- pcOut=0xFFFFFFF8 (via branch), sequential edge -> pcOut=0x00000000. stall=1 for 2 edges -> pcOut stays 0. Simultaneous call+ret while stalled -> no change in pcOut, rasCount or flags.
- Assert reset between clock edges while pcOut=0x400 and rasCount=2 -> pcOut=RESET_PC, rasCount=0, flags=0 immediately, with no clock edge required.
